vga_fb_pixel_fetch: RTL and testbench
=====================================

Name: vga_fb_pixel_fetch

Overview:
- Downstream stage of the 640x480 VGA timing core in the Mandelbrot design.
- Converts each pixel position (x, y) into a read of a double-buffered 160x120 iteration-count framebuffer, with 4x4 pixel replication.
- Maps each iteration count to 4-bit RGB through a palette.
- Delays HS/VS so they stay aligned with the colour data. Bank swaps are accepted from the Mandelbrot compute engine only during vertical blanking.

Parameters:
- ITER_W, 8, width of the iteration count stored per framebuffer entry.
- MAX_ITER, 255, count meaning "did not escape"; this value is drawn black.
- FB_W, 160, framebuffer width (640 >> 2).
- FB_H, 120, framebuffer height (480 >> 2).
- ADDR_W, 15, framebuffer address width; must satisfy 2^ADDR_W >= FB_W*FB_H.

Ports:
- i_clk  in  1  system clock, 100 MHz.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_pix_stb  in  1  pixel strobe, one clk wide; consecutive strobes are at least 2 clks apart.
- i_x  in  10  current pixel x from the timing core.
- i_y  in  9  current pixel y from the timing core.
- i_hs  in  1  horizontal sync from the timing core, active low.
- i_vs  in  1  vertical sync from the timing core, active low.
- o_fb_rd_en  out  1  framebuffer read enable, one clk pulse.
- o_fb_addr  out  ADDR_W  framebuffer read address.
- o_fb_bank  out  1  bank currently displayed; the compute engine writes the other bank.
- i_fb_data  in  ITER_W  read data, valid 1 clk after o_fb_rd_en.
- i_swap_req  in  1  one-clk pulse: the compute engine has finished a frame in the back bank.
- o_swap_ack  out  1  one-clk pulse: the swap has been performed.
- o_hs  out  1  delayed HS.
- o_vs  out  1  delayed VS.
- o_r  out  4  red.
- o_g  out  4  green.
- o_b  out  4  blue.

Behaviour:
- Reset is asynchronous. Under reset:
  - o_hs = 1 and o_vs = 1 (inactive).
  - o_r, o_g, o_b = 0.
  - o_fb_rd_en = 0, o_fb_addr = 0, o_fb_bank = 0, o_swap_ack = 0.
  - Swap-pending flag cleared; all pipeline valid/active bits cleared.
- The pipeline advances only on a clk where i_pix_stb = 1. Nothing changes between strobes, except o_fb_rd_en and o_swap_ack dropping back to 0.
- Stage 0 (strobe n):
  - active0 = (i_x < 640) && (i_y < 480).
  - If active0: o_fb_addr = (i_y>>2)*160 + (i_x>>2), computed as (yq<<7)+(yq<<5)+xq with no multiplier; o_fb_rd_en pulses for 1 clk.
  - If not active0: no read issued; o_fb_addr holds its previous value.
  - hs, vs and active0 are captured into delay stage 1.
- Stage 1 (strobe n+1):
  - Capture i_fb_data into the iteration register; the data returned 1 clk after the read and is stable by the next strobe.
  - If active is 0, the iteration register is forced to MAX_ITER.
  - hs, vs and active shift to delay stage 2.
- Stage 2 (strobe n+2): register the palette output into o_r/o_g/o_b and the delayed sync into o_hs/o_vs.
- Total latency from timing-core position to colour/sync output is exactly 2 strobes. HS and VS keep exact alignment with RGB.
- Palette (combinational):
  - iter == MAX_ITER or inactive -> RGB = 0,0,0.
  - Otherwise r = iter[3:0], g = iter[7:4], b = ~iter[3:0].
  - The palette uses the low 8 bits of iter; upper bits are ignored when ITER_W > 8.
- Bank swap:
  - i_swap_req sets the pending flag.
  - Frame boundary = a strobe with i_x == 0 and i_y == 480 (first pixel of vertical blank).
  - At a frame boundary with pending = 1 (including a req arriving on that same clk): o_fb_bank toggles, pending clears, o_swap_ack = 1 for 1 clk.
  - A repeated req while already pending is absorbed (one swap only).
  - A req on the same clk as o_swap_ack sets pending again for the next frame.
  - No swap happens at any point other than the frame boundary.
- Reads issued after the toggle use the new bank. No reads are issued during blanking, so no torn frame is possible.
- Reset mid-frame: the pipeline flushes, outputs go to the reset values, and the bank returns to 0. Normal output resumes 2 strobes after reset deasserts.

Decomposition:
- Shared package vga_pkg holds:
  - constants H_ACTIVE = 640, V_ACTIVE = 480, FB_W, FB_H, the scale shift 2;
  - the MAX_ITER default;
  - a typedef rgb444_t for {r, g, b}.
- One sub-module, mandel_palette: combinational iter -> rgb444_t. It is reused by any future palette-select logic.

Test Plan:
- Reset: hold i_rst_n = 0 while toggling strobes -> o_hs = 1, o_vs = 1, RGB = 0, o_fb_bank = 0, o_fb_rd_en stays 0. Release reset -> first RGB appears exactly 2 strobes after the first strobe.
- Addressing:
  - x = 5, y = 9 -> o_fb_addr = 2*160 + 1 = 321.
  - x = 639, y = 479 -> o_fb_addr = 19199.
  - x = 640 or y = 480 -> no o_fb_rd_en pulse.
- Palette/latency: RAM model returns 0x3A for the read at strobe n -> at strobe n+2, r = 0xA, g = 0x3, b = 0x5. A returned MAX_ITER = 255 -> RGB = 0.
- Sync alignment: HS falling edge presented at strobe n -> o_hs falls at strobe n+2. VS checked the same way over a full frame of 800x525 strobes.
- Swap timing:
  - i_swap_req pulse at y = 100 -> o_fb_bank toggles and o_swap_ack pulses exactly at the x = 0, y = 480 strobe.
  - Two reqs in one frame -> a single toggle.
  - No req -> the bank is unchanged across 3 frames.
- Simultaneous: req on the same clk as the boundary strobe -> swap that boundary. Req on the o_swap_ack clk -> second swap at the next frame boundary.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA/Mandelbrot constants and colour type.
// Used by the pixel fetch stage and the palette; holds no logic.
package vga_pkg;
    localparam logic [9:0] H_ACTIVE     = 10'd640;
    localparam logic [8:0] V_ACTIVE     = 9'd480;
    localparam int         FB_W         = 160;
    localparam int         FB_H         = 120;
    localparam int         SCALE_SH     = 2;
    localparam int         MAX_ITER_DEF = 255;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;
endpackage

// File: rtl/vga_fb_pixel_fetch_if.sv
// Framebuffer read port plus the bank swap handshake with the compute engine.
// master = pixel fetch stage, slave = framebuffer / compute engine side.
interface vga_fb_pixel_fetch_if #(
    parameter int ADDR_W = 15,
    parameter int ITER_W = 8
);
    logic              fb_rd_en;
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_bank;
    logic [ITER_W-1:0] fb_data;
    logic              swap_req;
    logic              swap_ack;

    modport master (
        output fb_rd_en, fb_addr, fb_bank, swap_ack,
        input  fb_data, swap_req
    );

    modport slave (
        input  fb_rd_en, fb_addr, fb_bank, swap_ack,
        output fb_data, swap_req
    );
endinterface

// File: rtl/mandel_palette.sv
// Iteration count to RGB444; non-escaping points (MAX_ITER) are black.
// Purely combinational, no latency, no flow control.
module mandel_palette
    import vga_pkg::*;
#(
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = MAX_ITER_DEF
) (
    input  logic [ITER_W-1:0] iter,
    output rgb444_t           rgb
);
    always_comb begin
        rgb = '0;
        if (iter != ITER_W'(MAX_ITER)) begin
            rgb.r = iter[3:0];
            rgb.g = iter[7:4];
            rgb.b = ~iter[3:0];
        end
    end
endmodule

// File: rtl/vga_fb_pixel_fetch.sv
// Pixel position -> 4x-replicated framebuffer read -> palette RGB, with HS/VS delayed to match.
// Latency exactly 2 pixel strobes; no backpressure, state only advances on i_pix_stb.
module vga_fb_pixel_fetch
    import vga_pkg::*;
#(
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = MAX_ITER_DEF,
    parameter int FB_W     = vga_pkg::FB_W,
    parameter int FB_H     = vga_pkg::FB_H,
    parameter int ADDR_W   = 15
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_pix_stb,
    input  logic [9:0]           i_x,
    input  logic [8:0]           i_y,
    input  logic                 i_hs,
    input  logic                 i_vs,
    vga_fb_pixel_fetch_if.master fb,
    output logic                 o_hs,
    output logic                 o_vs,
    output logic [3:0]           o_r,
    output logic [3:0]           o_g,
    output logic [3:0]           o_b
);
    logic [7:0]        xq;
    logic [6:0]        yq;
    logic              active0;
    logic              frame_bnd;
    logic [ADDR_W-1:0] addr0;
    logic              swap_pend;

    logic              hs1, vs1, act1;
    logic              hs2, vs2;
    logic [ITER_W-1:0] iter_q;
    rgb444_t           pal_rgb;

    assign xq = i_x[9:SCALE_SH];
    assign yq = i_y[8:SCALE_SH];

    // Comparing the quarter-scale coordinates is equivalent to x<640 && y<480.
    assign active0   = (xq < 8'(FB_W)) && (yq < 7'(FB_H));
    assign addr0     = (ADDR_W'(yq) << 7) + (ADDR_W'(yq) << 5) + ADDR_W'(xq);
    assign frame_bnd = i_pix_stb && (i_x == 10'd0) && (i_y == V_ACTIVE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fb.fb_rd_en <= 1'b0;
            fb.fb_addr  <= '0;
            fb.fb_bank  <= 1'b0;
            fb.swap_ack <= 1'b0;
            swap_pend   <= 1'b0;
        end else begin
            fb.fb_rd_en <= i_pix_stb && active0;
            fb.swap_ack <= 1'b0;
            if (i_pix_stb && active0) begin
                fb.fb_addr <= addr0;
            end
            // A request landing on the boundary strobe itself is honoured immediately.
            if (frame_bnd && (swap_pend || fb.swap_req)) begin
                fb.fb_bank  <= ~fb.fb_bank;
                fb.swap_ack <= 1'b1;
                swap_pend   <= 1'b0;
            end else if (fb.swap_req) begin
                swap_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hs1    <= 1'b1;
            vs1    <= 1'b1;
            act1   <= 1'b0;
            hs2    <= 1'b1;
            vs2    <= 1'b1;
            iter_q <= ITER_W'(MAX_ITER);
            o_hs   <= 1'b1;
            o_vs   <= 1'b1;
            o_r    <= '0;
            o_g    <= '0;
            o_b    <= '0;
        end else if (i_pix_stb) begin
            hs1    <= i_hs;
            vs1    <= i_vs;
            act1   <= active0;
            // Blanked positions become MAX_ITER so the palette renders them black.
            iter_q <= act1 ? fb.fb_data : ITER_W'(MAX_ITER);
            hs2    <= hs1;
            vs2    <= vs1;
            o_hs   <= hs2;
            o_vs   <= vs2;
            o_r    <= pal_rgb.r;
            o_g    <= pal_rgb.g;
            o_b    <= pal_rgb.b;
        end
    end

    mandel_palette #(
        .ITER_W   (ITER_W),
        .MAX_ITER (MAX_ITER)
    ) u_palette (
        .iter (iter_q),
        .rgb  (pal_rgb)
    );
endmodule

// File: tb/tb_vga_fb_pixel_fetch.sv
// Directed bench for vga_fb_pixel_fetch: addressing, palette, sync latency, bank swap, reset.
module tb_vga_fb_pixel_fetch;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pix_stb = 1'b0;
    logic [9:0] x = '0;
    logic [8:0] y = '0;
    logic       hs = 1'b1;
    logic       vs = 1'b1;
    logic       o_hs, o_vs;
    logic [3:0] o_r, o_g, o_b;

    int n_cmp = 0;
    int n_err = 0;

    logic seen_rd, late_rd, seen_ack, late_ack;

    vga_fb_pixel_fetch_if #(.ADDR_W(15), .ITER_W(8)) fb ();

    vga_fb_pixel_fetch dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_pix_stb (pix_stb),
        .i_x       (x),
        .i_y       (y),
        .i_hs      (hs),
        .i_vs      (vs),
        .fb        (fb),
        .o_hs      (o_hs),
        .o_vs      (o_vs),
        .o_r       (o_r),
        .o_g       (o_g),
        .o_b       (o_b)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_rd(input logic [14:0] a, input logic bank);
        if (a == 15'd321)   return 8'h3A;
        if (a == 15'd19199) return 8'hFF;
        return a[7:0] ^ (bank ? 8'h80 : 8'h00);
    endfunction

    always @(posedge clk) begin
        if (fb.fb_rd_en) fb.fb_data <= ram_rd(fb.fb_addr, fb.fb_bank);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One strobe followed by one idle clk; req_now rides with the strobe, req_next on the clk after.
    task automatic pix(input logic [9:0] px, input logic [8:0] py, input logic phs, input logic pvs,
                       input logic req_now, input logic req_next);
        @(negedge clk);
        x = px; y = py; hs = phs; vs = pvs; pix_stb = 1'b1; fb.swap_req = req_now;
        @(negedge clk);
        pix_stb = 1'b0; fb.swap_req = req_next;
        seen_rd = fb.fb_rd_en; seen_ack = fb.swap_ack;
        @(negedge clk);
        fb.swap_req = 1'b0;
        late_rd = fb.fb_rd_en; late_ack = fb.swap_ack;
    endtask

    task automatic req_pulse();
        @(negedge clk); fb.swap_req = 1'b1;
        @(negedge clk); fb.swap_req = 1'b0;
    endtask

    initial begin
        fb.swap_req = 1'b0;
        fb.fb_data  = '0;
        #3 rst_n = 1'b0;

        // Held in reset while strobes run
        for (int i = 0; i < 3; i++) begin
            pix(10'd5, 9'd9, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("rst_rd_en", seen_rd, 0);
            chk("rst_hs", o_hs, 1);
            chk("rst_vs", o_vs, 1);
            chk("rst_rgb", {o_r, o_g, o_b}, 12'h000);
            chk("rst_bank", fb.fb_bank, 0);
            chk("rst_ack", seen_ack, 0);
        end
        @(negedge clk); rst_n = 1'b1;

        pix(10'd5, 9'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("s1_rd", seen_rd, 1);
        chk("s1_rd_drop", late_rd, 0);
        chk("s1_addr", fb.fb_addr, 321);
        chk("s1_rgb", {o_r, o_g, o_b}, 12'h000);

        pix(10'd639, 9'd479, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("s2_rd", seen_rd, 1);
        chk("s2_addr", fb.fb_addr, 19199);
        chk("s2_rgb", {o_r, o_g, o_b}, 12'h000);

        pix(10'd640, 9'd10, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("s3_no_rd", seen_rd, 0);
        chk("s3_addr_hold", fb.fb_addr, 19199);
        chk("s3_rgb_3a", {o_r, o_g, o_b}, 12'hA35);
        chk("s3_hs", o_hs, 1);

        pix(10'd100, 9'd480, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("s4_no_rd", seen_rd, 0);
        chk("s4_rgb_max", {o_r, o_g, o_b}, 12'h000);
        chk("s4_hs", o_hs, 1);
        chk("s4_ack", seen_ack, 0);

        pix(10'd8, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("s5_addr", fb.fb_addr, 2);
        chk("s5_rgb_inact", {o_r, o_g, o_b}, 12'h000);
        chk("s5_hs_fall", o_hs, 0);
        chk("s5_vs", o_vs, 1);

        pix(10'd13, 9'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("s6_addr", fb.fb_addr, 163);
        chk("s6_hs", o_hs, 1);
        chk("s6_vs_fall", o_vs, 0);

        pix(10'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("s7_rgb", {o_r, o_g, o_b}, 12'h20D);
        chk("s7_vs", o_vs, 1);

        pix(10'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("s8_rgb", {o_r, o_g, o_b}, 12'h3AC);

        // Request mid-frame, swap only at the boundary
        pix(10'd0, 9'd100, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t1_ack_early", seen_ack, 0);
        chk("t1_bank_early", fb.fb_bank, 0);
        pix(10'd5, 9'd300, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t1_bank_mid", fb.fb_bank, 0);
        pix(10'd0, 9'd480, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_ack", seen_ack, 1);
        chk("t1_ack_drop", late_ack, 0);
        chk("t1_bank", fb.fb_bank, 1);

        // Two requests in one frame give one swap
        req_pulse();
        pix(10'd1, 9'd480, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_not_bnd", fb.fb_bank, 1);
        req_pulse();
        pix(10'd0, 9'd480, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_ack", seen_ack, 1);
        chk("t2_bank", fb.fb_bank, 0);
        pix(10'd0, 9'd10, 1'b1, 1'b1, 1'b0, 1'b0);
        pix(10'd0, 9'd480, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_no_ack", seen_ack, 0);
        chk("t2_bank_once", fb.fb_bank, 0);

        // No request across three frames
        for (int f = 0; f < 3; f++) begin
            pix(10'd0, 9'd10, 1'b1, 1'b1, 1'b0, 1'b0);
            pix(10'd0, 9'd480, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("t3_ack", seen_ack, 0);
            chk("t3_bank", fb.fb_bank, 0);
        end

        // Request on the boundary strobe itself
        pix(10'd0, 9'd480, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t4_ack", seen_ack, 1);
        chk("t4_bank", fb.fb_bank, 1);

        // Request on the ack clk re-arms for the next frame
        req_pulse();
        pix(10'd0, 9'd480, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t5_ack1", seen_ack, 1);
        chk("t5_bank1", fb.fb_bank, 0);
        pix(10'd0, 9'd10, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t5_mid_ack", seen_ack, 0);
        chk("t5_mid_bank", fb.fb_bank, 0);
        pix(10'd0, 9'd480, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_ack2", seen_ack, 1);
        chk("t5_bank2", fb.fb_bank, 1);

        // Reads now come from bank 1
        pix(10'd8, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        pix(10'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        pix(10'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("b1_rgb", {o_r, o_g, o_b}, 12'h28D);

        pix(10'd5, 9'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        pix(10'd5, 9'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("b1_rgb_a0", {o_r, o_g, o_b}, 12'h08F);
        pix(10'd5, 9'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_rgb", {o_r, o_g, o_b}, 12'hA35);
        chk("pre_rst_hs", o_hs, 0);

        // Reset mid-frame
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk("mid_rst_hs", o_hs, 1);
        chk("mid_rst_vs", o_vs, 1);
        chk("mid_rst_rgb", {o_r, o_g, o_b}, 12'h000);
        chk("mid_rst_bank", fb.fb_bank, 0);
        @(negedge clk); rst_n = 1'b1;

        pix(10'd5, 9'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("post_rst1", {o_r, o_g, o_b}, 12'h000);
        pix(10'd5, 9'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("post_rst2", {o_r, o_g, o_b}, 12'h000);
        pix(10'd5, 9'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("post_rst3", {o_r, o_g, o_b}, 12'hA35);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
